// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues 16-bit fetches over a request/ack memory port
// and writes the IF/ID register, handling stalls, redirects, squash and HLT.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] pc_in,
  output logic [15:0] IF_instr,
  output logic        IF_inval,
  output logic        ifid_wen,
  output logic        halted
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StHalt} state_e;

  state_e      r_state, w_state_d;
  logic [15:0] r_pc, w_pc_d;
  logic [15:0] r_held, w_held_d;
  logic [15:0] r_req_addr, w_req_addr_d;
  logic        r_squash, w_squash_d;
  logic [15:0] w_pc_plus2;
  logic [15:0] w_redir_pc;

  assign w_pc_plus2 = r_pc + 16'd2;
  assign w_redir_pc = {redirect_pc[15:1], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_pc       <= 16'h0000;
      r_held     <= 16'h0000;
      r_req_addr <= 16'h0000;
      r_squash   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_held     <= w_held_d;
      r_req_addr <= w_req_addr_d;
      r_squash   <= w_squash_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_held_d     = r_held;
    w_req_addr_d = r_req_addr;
    w_squash_d   = r_squash;
    imem_req     = 1'b0;
    // A squashed request keeps its original address on the bus until acked.
    imem_addr    = r_squash ? r_req_addr : r_pc;
    pc_in        = w_pc_plus2;
    IF_instr     = 16'h0000;
    IF_inval     = 1'b1;
    ifid_wen     = ~stall;
    halted       = 1'b0;

    case (r_state)
      StIdle: begin
        ifid_wen  = 1'b0;
        w_state_d = StFetch;
      end

      StFetch: begin
        imem_req = 1'b1;
        if (redirect) begin
          w_pc_d     = w_redir_pc;
          w_squash_d = ~imem_ack;
          if (!imem_ack && !r_squash) w_req_addr_d = r_pc;
        end else if (imem_ack) begin
          if (r_squash) begin
            w_squash_d = 1'b0;
          end else begin
            IF_instr = imem_data;
            IF_inval = 1'b0;
            if (stall) begin
              w_held_d  = imem_data;
              w_state_d = StHold;
            end else if (imem_data[15:12] == 4'hF) begin
              w_state_d = StHalt;
            end else begin
              w_pc_d = w_pc_plus2;
            end
          end
        end
      end

      StHold: begin
        if (redirect) begin
          w_pc_d    = w_redir_pc;
          w_state_d = StFetch;
        end else begin
          IF_instr = r_held;
          IF_inval = 1'b0;
          if (!stall) begin
            if (r_held[15:12] == 4'hF) begin
              w_state_d = StHalt;
            end else begin
              w_pc_d    = w_pc_plus2;
              w_state_d = StFetch;
            end
          end
        end
      end

      StHalt: begin
        halted = 1'b1;
        if (redirect) begin
          w_pc_d    = w_redir_pc;
          w_state_d = StFetch;
        end
      end

      default: w_state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] pc_in;
  logic [15:0] IF_instr;
  logic        IF_inval;
  logic        ifid_wen;
  logic        halted;

  int n_chk;
  int n_pass;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .pc_in      (pc_in),
    .IF_instr   (IF_instr),
    .IF_inval   (IF_inval),
    .ifid_wen   (ifid_wen),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [15:0] data, input logic stl,
                       input logic rd, input logic [15:0] rpc);
    imem_ack    = ack;
    imem_data   = data;
    stall       = stl;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " req"},    {15'd0, imem_req}, 16'h0000);
    check({tag, " addr"},   imem_addr,         16'h0000);
    check({tag, " instr"},  IF_instr,          16'h0000);
    check({tag, " inval"},  {15'd0, IF_inval}, 16'h0001);
    check({tag, " pc_in"},  pc_in,             16'h0002);
    check({tag, " wen"},    {15'd0, ifid_wen}, 16'h0000);
    check({tag, " halted"}, {15'd0, halted},   16'h0000);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    check_reset_outs("rst0");

    // Release reset: one IDLE cycle, redirect ignored there.
    cyc();
    rst = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0300);
    check("idle wen", {15'd0, ifid_wen}, 16'h0000);
    check("idle req", {15'd0, imem_req}, 16'h0000);

    // Sequential fetch with ack every cycle.
    cyc();
    drive(1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000);
    check("seq0 req", {15'd0, imem_req}, 16'h0001);
    check("seq0 addr", imem_addr, 16'h0000);
    check("seq0 instr", IF_instr, 16'h1111);
    check("seq0 inval", {15'd0, IF_inval}, 16'h0000);
    check("seq0 pc_in", pc_in, 16'h0002);
    check("seq0 wen", {15'd0, ifid_wen}, 16'h0001);
    cyc();
    drive(1'b1, 16'h2222, 1'b0, 1'b0, 16'h0000);
    check("seq1 addr", imem_addr, 16'h0002);
    check("seq1 instr", IF_instr, 16'h2222);
    check("seq1 pc_in", pc_in, 16'h0004);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    check("seq2 addr", imem_addr, 16'h0004);
    check("seq2 bubble inval", {15'd0, IF_inval}, 16'h0001);
    check("seq2 bubble instr", IF_instr, 16'h0000);

    // Redirect with ack in the same cycle: data dropped, odd target rounded down.
    drive(1'b1, 16'h5555, 1'b0, 1'b1, 16'h0011);
    check("rdack inval", {15'd0, IF_inval}, 16'h0001);
    check("rdack instr", IF_instr, 16'h0000);

    // Stall on delivery, hold for three cycles.
    cyc();
    drive(1'b1, 16'hA5A5, 1'b1, 1'b0, 16'h0000);
    check("st addr", imem_addr, 16'h0010);
    check("st instr", IF_instr, 16'hA5A5);
    check("st wen", {15'd0, ifid_wen}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      check("hold req", {15'd0, imem_req}, 16'h0000);
      check("hold instr", IF_instr, 16'hA5A5);
      check("hold inval", {15'd0, IF_inval}, 16'h0000);
      check("hold pc_in", pc_in, 16'h0012);
    end
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    check("unhold instr", IF_instr, 16'hA5A5);
    check("unhold wen", {15'd0, ifid_wen}, 16'h0001);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    check("unhold next addr", imem_addr, 16'h0012);
    check("unhold next req", {15'd0, imem_req}, 16'h0001);

    // Move to 0x0020, then redirect an unacked request.
    drive(1'b1, 16'h0000, 1'b0, 1'b1, 16'h0020);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    check("sq req addr", imem_addr, 16'h0020);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100);
    check("sq rd inval", {15'd0, IF_inval}, 16'h0001);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    check("sq addr held", imem_addr, 16'h0020);
    check("sq req held", {15'd0, imem_req}, 16'h0001);
    cyc();
    drive(1'b1, 16'h7777, 1'b0, 1'b0, 16'h0000);
    check("sq ack inval", {15'd0, IF_inval}, 16'h0001);
    check("sq ack instr", IF_instr, 16'h0000);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    check("sq new addr", imem_addr, 16'h0100);

    // HLT at 0x0040.
    drive(1'b1, 16'h0000, 1'b0, 1'b1, 16'h0040);
    cyc();
    drive(1'b1, 16'hF000, 1'b0, 1'b0, 16'h0000);
    check("hlt instr", IF_instr, 16'hF000);
    check("hlt inval", {15'd0, IF_inval}, 16'h0000);
    cyc();
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    check("halt halted", {15'd0, halted}, 16'h0001);
    check("halt req", {15'd0, imem_req}, 16'h0000);
    check("halt pc", imem_addr, 16'h0040);
    check("halt inval", {15'd0, IF_inval}, 16'h0001);
    check("halt wen", {15'd0, ifid_wen}, 16'h0000);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0008);
    check("halt rd halted", {15'd0, halted}, 16'h0001);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    check("resume halted", {15'd0, halted}, 16'h0000);
    check("resume req", {15'd0, imem_req}, 16'h0001);
    check("resume addr", imem_addr, 16'h0008);

    // Wrap from 0xFFFE.
    drive(1'b1, 16'h0000, 1'b0, 1'b1, 16'hFFFE);
    cyc();
    drive(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000);
    check("wrap addr", imem_addr, 16'hFFFE);
    check("wrap instr", IF_instr, 16'h1234);
    check("wrap pc_in", pc_in, 16'h0000);
    cyc();
    drive(1'b1, 16'h0AAA, 1'b0, 1'b0, 16'h0000);
    check("wrap next addr", imem_addr, 16'h0000);

    // Enter HOLD at pc 0x0002, then reset asynchronously.
    cyc();
    drive(1'b1, 16'h4321, 1'b1, 1'b0, 16'h0000);
    cyc();
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    check("prerst instr", IF_instr, 16'h4321);
    check("prerst pc_in", pc_in, 16'h0004);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outs("asyncrst");

    // Late ack during reset and in IDLE is ignored.
    cyc();
    drive(1'b1, 16'hF000, 1'b0, 1'b0, 16'h0000);
    check("rst late ack inval", {15'd0, IF_inval}, 16'h0001);
    rst = 1'b0;
    cyc();
    drive(1'b1, 16'hF000, 1'b0, 1'b0, 16'h0000);
    check("idle late ack halted", {15'd0, halted}, 16'h0000);
    check("post rst addr", imem_addr, 16'h0000);
    check("post rst req", {15'd0, imem_req}, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
